// File: rtl/imem_fetch.sv
// imem_fetch: instruction memory with a NOP-clear sequence, a program-load mode
// and a one-cycle-latency valid/ready fetch port with flush support.
//
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   load_en, load_we,             - program-load mode request, write strobe,
//   load_addr, load_data            byte address and instruction word
//   req_valid, req_pc, req_ready  - fetch request handshake
//   rsp_valid, rsp_ready,         - registered fetch response handshake,
//   rsp_instr, rsp_pc, rsp_fault    fetched word, its PC, misaligned/out-of-range
//   flush                         - drop the pending response, block requests
//   state_o                       - CLEAR=0, RUN=1, LOAD=2
module imem_fetch #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_pc,
    output logic        rsp_fault,
    input  logic        flush,
    output logic [1:0]  state_o
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_instr_q, rsp_instr_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic          rsp_fault_q, rsp_fault_d;

    // Not reset: contents are defined by the CLEAR sweep alone.
    logic [31:0]   mem_q [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic          req_ok;
    logic          load_ok;
    logic          rsp_free;
    logic          req_hs;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] load_idx;

    assign req_ok   = (req_pc[1:0] == 2'b00) && (req_pc < MEM_BYTES);
    assign load_ok  = (load_addr[1:0] == 2'b00) && (load_addr < MEM_BYTES);
    assign req_idx  = req_pc[AW+1:2];
    assign load_idx = load_addr[AW+1:2];

    // Response slot is free after this edge if empty or being consumed.
    assign rsp_free  = ~rsp_valid_q | rsp_ready;
    assign req_ready = (state_q == RUN) & ~load_en & ~flush & rsp_free;
    assign req_hs    = req_valid & req_ready;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = load_data;
        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = NOP_INSTR;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end
            end
            RUN: begin
                // Enter LOAD only once no response survives this edge.
                if (load_en && (rsp_free || flush)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                mem_we    = load_we & load_ok;
                mem_waddr = load_idx;
                if (!load_en) begin
                    state_d = RUN;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_instr_d = rsp_instr_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_fault_d = rsp_fault_q;
        if (flush) begin
            rsp_valid_d = 1'b0;
        end else if (req_hs) begin
            rsp_valid_d = 1'b1;
            rsp_pc_d    = req_pc;
            rsp_fault_d = ~req_ok;
            rsp_instr_d = req_ok ? mem_q[req_idx] : NOP_INSTR;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= NOP_INSTR;
            rsp_pc_q    <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_instr = rsp_instr_q;
    assign rsp_pc    = rsp_pc_q;
    assign rsp_fault = rsp_fault_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: scoreboard bench for imem_fetch.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_imem_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h00a0_0513;
    localparam logic [31:0] W1  = 32'h0010_8093;
    localparam logic [31:0] W2  = 32'hfea0_cee3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_en = 1'b0;
    logic        load_we = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic        rsp_fault;
    logic        flush = 1'b0;
    logic [1:0]  state_o;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    imem_fetch #(.DEPTH(64), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_en(load_en), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_fault(rsp_fault),
        .flush(flush), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc,
                        input logic f);
        exp_t e;
        e.instr = ins;
        e.pc    = pc;
        e.fault = f;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request, wait (bounded) for acceptance, record expectation.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] ins,
                         input logic f, output int waited);
        req_valid = 1'b1;
        req_pc    = pc;
        #1;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!req_ready) chk("fetch_timeout", 32'd0, 32'd1);
        else push(ins, pc, f);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready && !flush) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", rsp_pc, 32'hffff_ffff);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_instr", rsp_instr, mon_e.instr);
                chk("rsp_pc", rsp_pc, mon_e.pc);
                chk("rsp_fault", 32'(rsp_fault), 32'(mon_e.fault));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int w;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_pc    = 32'h10;
        rsp_ready = 1'b1;
        #3;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_instr", rsp_instr, NOP);
        chk("rst_pc", rsp_pc, 32'd0);
        chk("rst_fault", 32'(rsp_fault), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);

        // Abort a CLEAR midway; the restart must run the full sweep.
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("clear_mid", 32'(state_o), 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (req_ready !== 1'b0 || state_o !== 2'd0) errs++;
            @(negedge clk);
        end
        chk("clear_len", 32'(errs), 32'd0);
        #1;
        chk("run_state", 32'(state_o), 32'd1);
        chk("run_ready", 32'(req_ready), 32'd1);
        push(NOP, 32'h10, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc(2);

        // Program load, with a misaligned and an out-of-range write.
        load_en = 1'b1;
        cyc(1);
        chk("load_state", 32'(state_o), 32'd2);
        load_we = 1'b1;
        load_addr = 32'h0;   load_data = W0;           cyc(1);
        load_addr = 32'h100; load_data = 32'hbadbadbb; cyc(1);
        load_addr = 32'h4;   load_data = W1;           cyc(1);
        load_addr = 32'hd;   load_data = 32'hdeadbeef; cyc(1);
        load_addr = 32'h8;   load_data = W2;           cyc(1);
        load_we = 1'b0;
        load_en = 1'b0;
        cyc(1);
        chk("load_exit", 32'(state_o), 32'd1);

        fetch(32'h0, W0, 1'b0, w);
        fetch(32'h4, W1, 1'b0, w);
        chk("b2b_4", 32'(w), 32'd0);
        fetch(32'h8, W2, 1'b0, w);
        chk("b2b_8", 32'(w), 32'd0);
        fetch(32'hc, NOP, 1'b0, w);
        fetch(32'h6, NOP, 1'b1, w);
        fetch(32'h100, NOP, 1'b1, w);
        req_valid = 1'b0;
        cyc(2);

        // Back-pressure: response held for 3 cycles.
        rsp_ready = 1'b0;
        fetch(32'h4, W1, 1'b0, w);
        req_pc = 32'h8;
        errs = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_pc !== 32'h4 ||
                rsp_instr !== W1 || rsp_fault !== 1'b0 ||
                req_ready !== 1'b0) errs++;
        end
        chk("stall_hold", 32'(errs), 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        fetch(32'h8, W2, 1'b0, w);
        chk("stall_release", 32'(w), 32'd0);
        req_valid = 1'b0;
        cyc(2);

        // Flush drops the pending response and blocks the request.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = 32'h0;
        cyc(1);
        req_pc = 32'h4;
        chk("flush_pre", 32'(rsp_valid), 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_block", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("flush_clear", 32'(rsp_valid), 32'd0);

        // load_en while a response is pending waits for the drain.
        fetch(32'h0, W0, 1'b0, w);
        req_valid = 1'b0;
        load_en   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("load_wait", 32'(state_o), 32'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        cyc(1);
        chk("load_drained", 32'(state_o), 32'd2);
        load_en = 1'b0;
        cyc(1);
        chk("load_back", 32'(state_o), 32'd1);

        cyc(3);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
